// File: rtl/opram_pkg.sv
// Shared types and width helpers for the multi-write LVT operand RAM (opram_lvt_mw).
package opram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } opram_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One LVT entry names the bank holding the live copy; a single bank still needs one bit.
  function automatic int lvt_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/opram_lvt_mw_if.sv
// Read/write port bundle of opram_lvt_mw; the master drives addresses and write data.
interface opram_lvt_mw_if
  import opram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 1,
  parameter int NR    = 7,
  parameter int NW    = 2
) ();

  localparam int AW_W = addr_w(DEPTH);

  logic [NR-1:0][AW_W-1:0]  A;
  logic [NR-1:0][WIDTH-1:0] Q;
  logic [NW-1:0]            WEN;
  logic [NW-1:0][AW_W-1:0]  AW;
  logic [NW-1:0][WIDTH-1:0] DI;
  logic                     READY;

  modport master (output A, WEN, AW, DI, input  Q, READY);
  modport slave  (input  A, WEN, AW, DI, output Q, READY);

endinterface

// File: rtl/opram_bank.sv
// One-write, NR-read asynchronous RAM bank. `_FPGA selects RAM64M8 slices (DEPTH <= 64),
// otherwise a behavioural array is used.
module opram_bank
  import opram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 1,
  parameter int NR    = 7
) (
  input  logic                           CLK,
  input  logic                           we,
  input  logic [addr_w(DEPTH)-1:0]       wa,
  input  logic [WIDTH-1:0]               wd,
  input  logic [NR-1:0][addr_w(DEPTH)-1:0] ra,
  output logic [NR-1:0][WIDTH-1:0]       rd
);

`ifdef _FPGA
  // Each RAM64M8 gives seven free read ports plus port H, which carries the write address.
  localparam int NG = (NR + 6) / 7;

  for (genvar w = 0; w < WIDTH; w++) begin : g_bit
    for (genvar g = 0; g < NG; g++) begin : g_grp
      logic [7:0][5:0] addr;
      logic [7:0]      dout;

      for (genvar k = 0; k < 7; k++) begin : g_port
        if (g * 7 + k < NR) begin : g_used
          assign addr[k]          = 6'(ra[g*7+k]);
          assign rd[g*7+k][w]     = dout[k];
        end else begin : g_unused
          assign addr[k] = '0;
        end
      end
      assign addr[7] = 6'(wa);

      RAM64M8 u_ram (
        .DOA(dout[0]), .DOB(dout[1]), .DOC(dout[2]), .DOD(dout[3]),
        .DOE(dout[4]), .DOF(dout[5]), .DOG(dout[6]), .DOH(dout[7]),
        .DIA(wd[w]), .DIB(wd[w]), .DIC(wd[w]), .DID(wd[w]),
        .DIE(wd[w]), .DIF(wd[w]), .DIG(wd[w]), .DIH(wd[w]),
        .ADDRA(addr[0]), .ADDRB(addr[1]), .ADDRC(addr[2]), .ADDRD(addr[3]),
        .ADDRE(addr[4]), .ADDRF(addr[5]), .ADDRG(addr[6]), .ADDRH(addr[7]),
        .WE(we), .WCLK(CLK)
      );
    end
  end
`else
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the storage array; it must map to LUTRAM, so the top clears it by sweeping.
  always_ff @(posedge CLK) begin
    if (we) mem[wa] <= wd;
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rd[r] = mem[ra[r]];
  end
`endif

endmodule

// File: rtl/opram_lvt_mw.sv
// DEPTH x WIDTH operand RAM, NR async reads, NW sync writes, one bank per write port plus a
// live-value table. Define OPRAM_BYPASS_EN for write-first reads; default is read-first.
module opram_lvt_mw
  import opram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 1,
  parameter int NR    = 7,
  parameter int NW    = 2
) (
  input  logic           CLK,
  input  logic           RST,
  opram_lvt_mw_if.slave  bus
);

  localparam int AW_W  = addr_w(DEPTH);
  localparam int LVT_W = lvt_w(NW);

  opram_state_e    state, state_next;
  logic [AW_W-1:0] cnt, cnt_next;
  logic            ready;

  logic [LVT_W-1:0] lvt [DEPTH];

  logic [NW-1:0]                     bank_we;
  logic [NW-1:0][AW_W-1:0]           bank_wa;
  logic [NW-1:0][WIDTH-1:0]          bank_wd;
  logic [NW-1:0][NR-1:0][WIDTH-1:0]  bank_rd;
  logic [NR-1:0][WIDTH-1:0]          q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    if (state == CLEAR) begin
      cnt_next = cnt + AW_W'(1);
      if (cnt == AW_W'(DEPTH - 1)) state_next = RUN;
    end
  end

  // Bank 0's write port belongs to the clear sweep until the storage is zeroed.
  always_comb begin
    ready = (state == RUN);
    for (int b = 0; b < NW; b++) begin
      bank_we[b] = ready & bus.WEN[b];
      bank_wa[b] = bus.AW[b];
      bank_wd[b] = bus.DI[b];
    end
    if (state == CLEAR) begin
      bank_we[0] = 1'b1;
      bank_wa[0] = cnt;
      bank_wd[0] = '0;
    end
  end

  // Ascending port order makes the highest-index port own the entry on a same-address collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++) lvt[e] <= '0;
    end else if (ready) begin
      for (int i = 0; i < NW; i++) begin
        if (bus.WEN[i]) lvt[bus.AW[i]] <= LVT_W'(i);
      end
    end
  end

  for (genvar b = 0; b < NW; b++) begin : g_bank
    opram_bank #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .NR    (NR)
    ) u_bank (
      .CLK (CLK),
      .we  (bank_we[b]),
      .wa  (bank_wa[b]),
      .wd  (bank_wd[b]),
      .ra  (bus.A),
      .rd  (bank_rd[b])
    );
  end

  always_comb begin
    q = '0;
    if (ready) begin
      for (int r = 0; r < NR; r++) begin
        for (int b = 0; b < NW; b++) begin
          if (lvt[bus.A[r]] == LVT_W'(b)) q[r] = bank_rd[b][r];
        end
`ifdef OPRAM_BYPASS_EN
        for (int i = 0; i < NW; i++) begin
          if (bus.WEN[i] && (bus.AW[i] == bus.A[r])) q[r] = bus.DI[i];
        end
`endif
      end
    end
  end

  assign bus.Q     = q;
  assign bus.READY = ready;

endmodule
